// File: rtl/alice4_io_pkg.sv
// Shared constants for the Alice4 FPGA/HPS I/O path: clock rate, button timing
// defaults and GP register bit-field offsets.
package alice4_io_pkg;

  localparam int CLOCK_HZ     = 50_000_000;
  localparam int MAX_CHANNELS = 16;

  function automatic int cycles_for_ms(input int ms);
    return (CLOCK_HZ / 1000) * ms;
  endfunction

  localparam int DEFAULT_DEBOUNCE_CYCLES   = cycles_for_ms(20);
  localparam int DEFAULT_LONG_PRESS_CYCLES = cycles_for_ms(1000);

  // f2h_value word 0 carries state/long, word 1 carries overrun/pending
  localparam int F2H_STATE_LSB   = 0;
  localparam int F2H_LONG_LSB    = 16;
  localparam int F2H_OVERRUN_LSB = 0;
  localparam int F2H_PENDING_LSB = 16;
  localparam int H2F_ACK_LSB     = 0;

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, debounce, long-press hold counter and
// toggle handshake with lost-event (overrun) tracking.
module button_channel
  import alice4_io_pkg::*;
#(
  parameter logic ACTIVE_LOW        = 1'b1,
  parameter int   DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int   DEBOUNCE_BITS     = 20,
  parameter int   LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter int   LONG_BITS         = 26
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_button,
  input  logic ack,
  output logic debounced,
  output logic f2h_state,
  output logic f2h_long,
  output logic f2h_overrun,
  output logic pending
);

  localparam logic [DEBOUNCE_BITS-1:0] DEBOUNCE_LAST = DEBOUNCE_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_BITS-1:0]     LONG_LAST     = LONG_BITS'(LONG_PRESS_CYCLES);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_channel: DEBOUNCE_CYCLES must be at least 2");
  end
  if (longint'(DEBOUNCE_CYCLES - 1) >= (longint'(1) << DEBOUNCE_BITS)) begin : g_bad_debounce_bits
    $error("button_channel: DEBOUNCE_BITS too narrow for DEBOUNCE_CYCLES-1");
  end
  if (longint'(LONG_PRESS_CYCLES) >= (longint'(1) << LONG_BITS)) begin : g_bad_long_bits
    $error("button_channel: LONG_BITS too narrow for LONG_PRESS_CYCLES");
  end

  logic                     sync1;
  logic                     sync2;
  logic                     corrected;
  logic                     debounce_done;
  logic                     long_raw;
  logic                     latch;
  logic                     missed;
  logic                     set_missed;
  logic [DEBOUNCE_BITS-1:0] debounce_count;
  logic [LONG_BITS-1:0]     hold_count;

  // Synchroniser idles at the inactive pad level so reset never looks like a press
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= raw_button;
      sync2 <= sync1;
    end
  end

  assign corrected     = sync2 ^ ACTIVE_LOW;
  assign debounce_done = (corrected != debounced) && (debounce_count == DEBOUNCE_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      debounced      <= 1'b0;
      debounce_count <= '0;
    end else if (corrected == debounced || debounce_done) begin
      debounced      <= corrected;
      debounce_count <= '0;
    end else begin
      debounce_count <= debounce_count + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_count <= '0;
    end else if (!debounced) begin
      hold_count <= '0;
    end else if (hold_count != LONG_LAST) begin
      hold_count <= hold_count + 1'b1;
    end
  end

  assign long_raw = (hold_count == LONG_LAST);
  assign pending  = (f2h_state != ack);
  assign latch    = !pending;

  // A transition back to the already-reported level means a press/release pair vanished
  assign set_missed = pending && debounce_done && (corrected == f2h_state);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f2h_state   <= 1'b0;
      f2h_long    <= 1'b0;
      f2h_overrun <= 1'b0;
      missed      <= 1'b0;
    end else begin
      if (latch) begin
        f2h_state   <= debounced;
        f2h_long    <= long_raw;
        f2h_overrun <= missed;
      end
      if (set_missed) begin
        missed <= 1'b1;
      end else if (latch) begin
        missed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/button_handshake_bank.sv
// Bank of independent button channels handshaking with the HPS through the
// GP registers; one button_channel per bit.
module button_handshake_bank
  import alice4_io_pkg::*;
#(
  parameter int                  CHANNELS          = 4,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK   = {CHANNELS{1'b1}},
  parameter int                  DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int                  DEBOUNCE_BITS     = 20,
  parameter int                  LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter int                  LONG_BITS         = 26
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_button,
  input  logic [CHANNELS-1:0] h2f_ack,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] f2h_state,
  output logic [CHANNELS-1:0] f2h_long,
  output logic [CHANNELS-1:0] f2h_overrun,
  output logic [CHANNELS-1:0] pending
);

  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("button_handshake_bank: CHANNELS must be 1..16");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
    button_channel #(
      .ACTIVE_LOW       (ACTIVE_LOW_MASK[i]),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .DEBOUNCE_BITS    (DEBOUNCE_BITS),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .LONG_BITS        (LONG_BITS)
    ) u_channel (
      .clock      (clock),
      .reset      (reset),
      .raw_button (raw_button[i]),
      .ack        (h2f_ack[i]),
      .debounced  (debounced[i]),
      .f2h_state  (f2h_state[i]),
      .f2h_long   (f2h_long[i]),
      .f2h_overrun(f2h_overrun[i]),
      .pending    (pending[i])
    );
  end

endmodule

// File: tb/tb_button_handshake_bank.sv
// Directed bench for button_handshake_bank: two channels, short debounce and
// long-press times so every boundary lands on a hand-counted cycle.
module tb_button_handshake_bank;

  logic       clock;
  logic       reset;
  logic [1:0] raw_button;
  logic [1:0] h2f_ack;
  logic [1:0] debounced;
  logic [1:0] f2h_state;
  logic [1:0] f2h_long;
  logic [1:0] f2h_overrun;
  logic [1:0] pending;

  int check_count = 0;
  int error_count = 0;

  button_handshake_bank #(
    .CHANNELS         (2),
    .ACTIVE_LOW_MASK  (2'b01),
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .raw_button (raw_button),
    .h2f_ack    (h2f_ack),
    .debounced  (debounced),
    .f2h_state  (f2h_state),
    .f2h_long   (f2h_long),
    .f2h_overrun(f2h_overrun),
    .pending    (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  logic [1:0] seen;

  initial begin
    reset      = 1'b1;
    raw_button = 2'b01;
    h2f_ack    = 2'b00;
    tick(2);
    check_output("reset_debounced", 16'(debounced), 16'h0);
    check_output("reset_state", 16'(f2h_state), 16'h0);
    check_output("reset_pending", 16'(pending), 16'h0);
    reset = 1'b0;

    seen = '0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      seen |= debounced | f2h_state | f2h_long | f2h_overrun | pending;
    end
    check_output("idle_all_zero", 16'(seen), 16'h0);

    raw_button[0] = 1'b0;
    tick(5);
    check_output("ch0_deb_before", 16'(debounced), 16'h0);
    tick(1);
    check_output("ch0_deb_rise", 16'(debounced), 16'h1);
    check_output("ch0_state_lag", 16'(f2h_state), 16'h0);
    tick(1);
    check_output("ch0_state_latched", 16'(f2h_state), 16'h1);
    check_output("ch0_pending", 16'(pending), 16'h1);
    h2f_ack[0] = 1'b1;
    tick(1);
    check_output("ch0_acked", 16'(pending), 16'h0);

    raw_button[1] = 1'b1;
    tick(3);
    raw_button[1] = 1'b0;
    seen = '0;
    for (int i = 0; i < 11; i++) begin
      tick(1);
      seen |= {debounced[1], f2h_state[1]} | {1'b0, pending[1]};
    end
    check_output("ch1_glitch", 16'(seen), 16'h0);

    check_output("ch0_long_early", 16'(f2h_long), 16'h0);
    tick(1);
    check_output("ch0_long_set", 16'(f2h_long), 16'h1);
    tick(3);
    raw_button[0] = 1'b1;
    tick(6);
    check_output("ch0_deb_fall", 16'(debounced), 16'h0);
    check_output("ch0_state_old", 16'(f2h_state), 16'h1);
    tick(1);
    check_output("ch0_state_fall", 16'(f2h_state), 16'h0);
    check_output("ch0_long_stale", 16'(f2h_long), 16'h1);
    check_output("ch0_release_pend", 16'(pending), 16'h1);
    h2f_ack[0] = 1'b0;
    tick(1);
    check_output("ch0_long_clear", 16'(f2h_long), 16'h0);
    check_output("ch0_release_ack", 16'(pending), 16'h0);

    raw_button[1] = 1'b1;
    tick(7);
    check_output("ch1_press_state", 16'(f2h_state), 16'h2);
    check_output("ch1_press_pend", 16'(pending), 16'h2);
    raw_button[1] = 1'b0;
    tick(8);
    check_output("ch1_release_deb", 16'(debounced), 16'h0);
    check_output("ch1_state_held", 16'(f2h_state), 16'h2);
    raw_button[1] = 1'b1;
    tick(8);
    check_output("ch1_repress_deb", 16'(debounced), 16'h2);
    check_output("ch1_overrun_hidden", 16'(f2h_overrun), 16'h0);
    h2f_ack[1] = 1'b1;
    tick(1);
    check_output("ch1_overrun_set", 16'(f2h_overrun), 16'h2);
    check_output("ch1_overrun_state", 16'(f2h_state), 16'h2);
    check_output("ch1_overrun_pend", 16'(pending), 16'h0);
    raw_button[1] = 1'b0;
    tick(7);
    check_output("ch1_clean_state", 16'(f2h_state), 16'h0);
    check_output("ch1_overrun_clear", 16'(f2h_overrun), 16'h0);
    check_output("ch1_clean_pend", 16'(pending), 16'h2);
    h2f_ack[1] = 1'b0;
    tick(1);
    check_output("ch1_clean_ack", 16'(pending), 16'h0);

    raw_button[1] = 1'b1;
    tick(7);
    check_output("pre_reset_pend", 16'(pending), 16'h2);
    raw_button[0] = 1'b0;
    tick(4);
    reset = 1'b1;
    #1;
    check_output("async_debounced", 16'(debounced), 16'h0);
    check_output("async_state", 16'(f2h_state), 16'h0);
    check_output("async_pending", 16'(pending), 16'h0);
    check_output("async_flags", 16'({f2h_long, f2h_overrun}), 16'h0);
    tick(1);
    reset = 1'b0;
    tick(5);
    check_output("post_reset_early", 16'(debounced), 16'h0);
    tick(1);
    check_output("post_reset_deb", 16'(debounced), 16'h3);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/button_handshake_bank.md
Name: button_handshake_bank

Overview:
- Multi-channel successor to the single home-button path: per channel it synchronises, debounces and polarity-corrects a raw button.
- Adds long-press detection and a toggle handshake with the HPS over the GP registers.
- New over the single-channel path: per-channel long-press and overrun (lost-event) reporting.
- Sits beside the GP register interface; its outputs pack into f2h_value and the ack bits come from h2f_value.

Parameters:
CHANNELS, 4, number of button channels (1..16)
ACTIVE_LOW_MASK, 4'b1111, bit i = 1 means raw_button[i] is active low
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles before the debounced state changes (20 ms at 50 MHz)
DEBOUNCE_BITS, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1
LONG_PRESS_CYCLES, 50_000_000, held cycles before the long flag sets (1 s)
LONG_BITS, 26, hold counter width; must hold LONG_PRESS_CYCLES

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
raw_button  in  CHANNELS  raw pad inputs, asynchronous
h2f_ack  in  CHANNELS  HPS acknowledge, one bit per channel, quasi-static
debounced  out  CHANNELS  debounced state, 1 = pressed
f2h_state  out  CHANNELS  latched pressed state presented to the HPS
f2h_long  out  CHANNELS  latched long-press flag presented to the HPS
f2h_overrun  out  CHANNELS  latched "an event pair was lost" flag
pending  out  CHANNELS  f2h_state != h2f_ack (HPS has not yet consumed)

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high. All outputs reset to 0.
- Reset of internal state:
  - Synchroniser flops reset to ACTIVE_LOW_MASK[i], the inactive raw level.
  - All counters and the missed bits reset to 0.
- Synchroniser: 2 flops per channel. The corrected level is sync2 ^ ACTIVE_LOW_MASK[i].
- Debounce:
  - Counter clears whenever corrected == debounced.
  - Otherwise it increments each cycle.
  - When the counter equals DEBOUNCE_CYCLES-1 and corrected != debounced: debounced <= corrected and the counter clears.
  - Latency from a clean raw edge to debounced = 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Hold counter:
  - Clears while debounced == 0.
  - Increments while debounced == 1, saturating at LONG_PRESS_CYCLES.
  - long_raw = (hold == LONG_PRESS_CYCLES); long_raw drops the cycle after debounced falls.
- Handshake, per channel:
  - When f2h_state == h2f_ack (latch cycle): f2h_state <= debounced, f2h_long <= long_raw, f2h_overrun <= missed, missed <= 0.
  - When f2h_state != h2f_ack: f2h_state, f2h_long and f2h_overrun hold.
  - When not pending, f2h_state tracks debounced with 1-cycle lag.
  - pending is combinational from f2h_state and h2f_ack.
- Long flag update: while idle, f2h_long follows long_raw each latch cycle, so a held button reports long after a prior ack.
- Missed bit:
  - Sets on any debounced transition that occurs while pending and whose new value equals f2h_state, meaning a full press/release pair vanished.
  - If a latch and a set occur in the same cycle, set wins: f2h_overrun gets the old missed and missed stays 1.
- Simultaneous debounced change and latch cycle: the latch captures the pre-change registered debounced. The next cycle latches again if the ack is still equal.
- Channels are fully independent; no arbitration.
- Reset mid-press: all state returns to idle. After release from reset, a still-held button produces an event after 2 + DEBOUNCE_CYCLES cycles.
- Width rule: counter compares use parameter widths. Out-of-range parameters (DEBOUNCE_CYCLES < 2, CHANNELS > 16) are a synthesis-time error.

Decomposition:
- Shared package alice4_io_pkg holds:
  - CLOCK_HZ = 50_000_000
  - Default DEBOUNCE_CYCLES and LONG_PRESS_CYCLES
  - f2h/h2f bit-field offset constants for packing into the GP registers
- One sub-module, button_channel, holds the synchroniser, debounce, hold counter, handshake and missed logic for a single channel. The top generates CHANNELS instances and concatenates their outputs.

Test Plan:
Bench uses CHANNELS=2, ACTIVE_LOW_MASK=2'b01, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16.
- Reset, then hold raw=2'b01 (both inactive) for 50 cycles -> all outputs stay 0; pending=0.
- Drive raw[0]=0 at cycle T -> debounced[0]=1 at T+6; f2h_state[0]=1 at T+7; pending[0]=1. Set h2f_ack[0]=1 -> pending[0]=0 next cycle.
- raw[1] pulses high for 3 cycles -> debounced[1], f2h_state[1] and pending[1] never assert.
- Hold channel 0 for 20 cycles with ack matching -> f2h_long[0]=1 at least 16 cycles after debounced rose. Release -> f2h_long[0]=0 on the latch after debounced falls.
- With ack[1]=0 held after an f2h_state[1]=1 event, do a release then re-press on raw[1] -> missed set. Toggle ack[1]=1 -> on that latch f2h_overrun[1]=1 and f2h_state[1]=1. A further clean handshake -> f2h_overrun[1]=0.
- Assert reset for 1 cycle mid-debounce (counter=2) with raw[0] held active -> all outputs 0 immediately. debounced[0]=1 exactly 6 cycles after reset deasserts.
